// File: rtl/rate_detect_pkg.sv
// Shared constants for rate_detect: default divider periods, FSM encoding and
// active-low 7-segment patterns (bit0=a .. bit6=g).
package rate_pkg;

    localparam int unsigned P0_DEF = 1;
    localparam int unsigned P1_DEF = 30000000;
    localparam int unsigned P2_DEF = 50000000;
    localparam int unsigned P3_DEF = 100000000;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] seg_digit(input logic [1:0] d);
        case (d)
            2'd0:    return SEG_0;
            2'd1:    return SEG_1;
            2'd2:    return SEG_2;
            default: return SEG_3;
        endcase
    endfunction

endpackage

// File: rtl/rate_detect_classify.sv
// Maps a measured period onto the rate code whose nominal period lies within
// +/- tol clocks; the lowest code wins when windows overlap.
module period_classify #(
    parameter int unsigned CNT_W = 28
) (
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] p0,
    input  logic [CNT_W-1:0] p1,
    input  logic [CNT_W-1:0] p2,
    input  logic [CNT_W-1:0] p3,
    input  logic [CNT_W-1:0] tol,
    output logic [1:0]       code,
    output logic             hit
);

    logic [CNT_W-1:0] pk [4];
    logic [3:0]       in_rng;

    assign pk = '{p0, p1, p2, p3};

    // Lower bound clamps at zero; upper bound carries one extra bit so it cannot wrap.
    for (genvar k = 0; k < 4; k++) begin : g_rng
        logic [CNT_W-1:0] lo;
        logic [CNT_W:0]   hi;
        assign lo        = (pk[k] > tol) ? (pk[k] - tol) : '0;
        assign hi        = {1'b0, pk[k]} + {1'b0, tol};
        assign in_rng[k] = (period >= lo) && ({1'b0, period} <= hi);
    end

    assign hit = |in_rng;

    always_comb begin
        if (in_rng[0])      code = 2'd0;
        else if (in_rng[1]) code = 2'd1;
        else if (in_rng[2]) code = 2'd2;
        else if (in_rng[3]) code = 2'd3;
        else                code = 2'd0;
    end

endmodule

// File: rtl/rate_detect.sv
// Measures tick spacing and decodes it back to the 2-bit rate select code.
// Optional RATE_DETECT_HEX_EN adds a registered 7-segment view of the lock.
module rate_detect
    import rate_pkg::*;
#(
    parameter int unsigned CNT_W   = 28,
    parameter int unsigned P0      = P0_DEF,
    parameter int unsigned P1      = P1_DEF,
    parameter int unsigned P2      = P2_DEF,
    parameter int unsigned P3      = P3_DEF,
    parameter int unsigned TOL     = 2,
    parameter int unsigned MATCH_N = 2,
    parameter int unsigned TIMEOUT = 110000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    output logic [1:0]       rate_sel,
    output logic             rate_valid,
    output logic             rate_err,
    output logic             timeout,
    output logic [CNT_W-1:0] period_out,
    output logic             new_meas
`ifdef RATE_DETECT_HEX_EN
    ,
    output logic [6:0]       hex_out
`endif
);

    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]       MATCH_C = 3'(MATCH_N);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [2:0]       match_q, match_d;
    logic [1:0]       sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;
    logic             new_meas_q, new_meas_d;

    logic [1:0]       cls_code;
    logic             cls_hit;

    period_classify #(.CNT_W(CNT_W)) u_classify (
        .period (cnt_q),
        .p0     (CNT_W'(P0)),
        .p1     (CNT_W'(P1)),
        .p2     (CNT_W'(P2)),
        .p3     (CNT_W'(P3)),
        .tol    (TOL_C),
        .code   (cls_code),
        .hit    (cls_hit)
    );

    // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        match_d    = match_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        new_meas_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d = ARMED;
                    cnt_d   = CNT_W'(1);
                    tmo_d   = 1'b0;
                end
            end
            ARMED: begin
                if (pulse_in) begin
                    cnt_d      = CNT_W'(1);
                    tmo_d      = 1'b0;
                    period_d   = cnt_q;
                    new_meas_d = 1'b1;
                    if (!cls_hit) begin
                        err_d   = 1'b1;
                        match_d = '0;
                        valid_d = 1'b0;
                    end else begin
                        err_d = 1'b0;
                        if (cls_code == sel_q && match_q != '0) begin
                            match_d = (match_q >= MATCH_C) ? MATCH_C : match_q + 3'd1;
                        end else begin
                            sel_d   = cls_code;
                            match_d = 3'd1;
                        end
                        valid_d = (match_d >= MATCH_C);
                    end
                end else if (cnt_q >= TMO_C) begin
                    // Rate code and last period stay visible across a timeout.
                    state_d = IDLE;
                    valid_d = 1'b0;
                    match_d = '0;
                    tmo_d   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            match_q    <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            new_meas_q <= 1'b0;
`ifdef RATE_DETECT_HEX_EN
            hex_out    <= SEG_DASH;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            match_q    <= match_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            new_meas_q <= new_meas_d;
`ifdef RATE_DETECT_HEX_EN
            hex_out    <= valid_d ? seg_digit(sel_d) : SEG_DASH;
`endif
        end
    end

    assign rate_sel   = sel_q;
    assign rate_valid = valid_q;
    assign rate_err   = err_q;
    assign timeout    = tmo_q;
    assign period_out = period_q;
    assign new_meas   = new_meas_q;

endmodule

// File: tb/tb_rate_detect.sv
// Bench for rate_detect: directed steps plus random pulse gaps, checked every
// cycle against an elapsed-time reference model.
module tb_rate_detect;

    localparam int CNT_W   = 8;
    localparam int P0      = 1;
    localparam int P1      = 6;
    localparam int P2      = 10;
    localparam int P3      = 20;
    localparam int TOL     = 1;
    localparam int MATCH_N = 2;
    localparam int TIMEOUT = 30;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             pulse_in;
    logic [1:0]       rate_sel;
    logic             rate_valid;
    logic             rate_err;
    logic             timeout;
    logic [CNT_W-1:0] period_out;
    logic             new_meas;
`ifdef RATE_DETECT_HEX_EN
    logic [6:0]       hex_out;
    logic [6:0]       seg_tab [4] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
    localparam logic [6:0] DASH = 7'b0111111;
`endif

    int checks   = 0;
    int failures = 0;

    int nominal [4] = '{P0, P1, P2, P3};

    // Reference model state: time-stamps instead of a counter.
    longint m_t    = 0;
    longint m_last = 0;
    bit     m_armed;
    int     m_run;
    int     m_sel;
    int     m_period;
    bit     m_valid, m_err, m_tmo, m_new;

    always #5 clk = ~clk;

    rate_detect #(
        .CNT_W   (CNT_W),
        .P0      (P0),
        .P1      (P1),
        .P2      (P2),
        .P3      (P3),
        .TOL     (TOL),
        .MATCH_N (MATCH_N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .rate_sel   (rate_sel),
        .rate_valid (rate_valid),
        .rate_err   (rate_err),
        .timeout    (timeout),
        .period_out (period_out),
        .new_meas   (new_meas)
`ifdef RATE_DETECT_HEX_EN
        ,
        .hex_out    (hex_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int classify(input int per);
        int d;
        for (int k = 0; k < 4; k++) begin
            d = per - nominal[k];
            if (d < 0) d = -d;
            if (d <= TOL) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input bit p, input bit r);
        longint el;
        int     k;
        m_t++;
        m_new = 1'b0;
        if (r) begin
            m_armed = 0; m_run = 0; m_sel = 0; m_period = 0;
            m_valid = 0; m_err = 0; m_tmo = 0;
        end else if (p) begin
            if (m_armed) begin
                el       = m_t - m_last;
                m_period = (el > CNT_MAX) ? CNT_MAX : int'(el);
                m_new    = 1'b1;
                k        = classify(m_period);
                if (k < 0) begin
                    m_err = 1; m_run = 0; m_valid = 0;
                end else begin
                    m_err = 0;
                    if (k == m_sel && m_run > 0) m_run++;
                    else begin
                        m_sel = k;
                        m_run = 1;
                    end
                    m_valid = (m_run >= MATCH_N);
                end
            end
            m_armed = 1;
            m_tmo   = 0;
            m_last  = m_t;
        end else if (m_armed && (m_t - m_last) >= TIMEOUT) begin
            m_armed = 0; m_valid = 0; m_run = 0; m_tmo = 1;
        end
    endtask

    task automatic compare_all();
        check("rate_sel",   32'(rate_sel),   32'(m_sel));
        check("rate_valid", 32'(rate_valid), 32'(m_valid));
        check("rate_err",   32'(rate_err),   32'(m_err));
        check("timeout",    32'(timeout),    32'(m_tmo));
        check("period_out", 32'(period_out), 32'(m_period));
        check("new_meas",   32'(new_meas),   32'(m_new));
`ifdef RATE_DETECT_HEX_EN
        check("hex_out", 32'(hex_out), 32'(m_valid ? seg_tab[m_sel] : DASH));
`endif
    endtask

    // Drive at the falling edge, model on the rising edge, sample 1 ns later.
    task automatic tick(input bit p, input bit r);
        pulse_in = p;
        reset    = r;
        @(posedge clk);
        model_step(p, r);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic pulse_after(input int gap);
        repeat (gap - 1) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    initial begin
        int gap;
        pulse_in = 1'b0;
        reset    = 1'b1;
        @(negedge clk);

        // Reset with pulse_in toggling
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        check("rst_sel", 32'(rate_sel), 0);
        check("rst_valid", 32'(rate_valid), 0);
        check("rst_err", 32'(rate_err), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_period", 32'(period_out), 0);
        check("rst_new_meas", 32'(new_meas), 0);
`ifdef RATE_DETECT_HEX_EN
        check("rst_hex", 32'(hex_out), 32'(7'b0111111));
`endif

        // Four pulses spaced 10 clocks
        tick(1'b1, 1'b0);
        check("arm_no_meas", 32'(new_meas), 0);
        pulse_after(10);
        check("p2_new_meas", 32'(new_meas), 1);
        check("p2_period", 32'(period_out), 10);
        check("p2_sel", 32'(rate_sel), 2);
        check("p2_valid", 32'(rate_valid), 0);
        pulse_after(10);
        check("p3_valid", 32'(rate_valid), 1);
`ifdef RATE_DETECT_HEX_EN
        check("p3_hex", 32'(hex_out), 32'(7'b0100100));
`endif
        pulse_after(10);
        tick(1'b0, 1'b0);
        check("strobe_one_cycle", 32'(new_meas), 0);

        // Continuous high pulse_in from a fresh reset
        tick(1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 1'b0);
            if (i >= 2) begin
                check("hold_period", 32'(period_out), 1);
                check("hold_sel", 32'(rate_sel), 0);
                check("hold_valid", 32'(rate_valid), (i >= 3) ? 1 : 0);
            end
        end

        // Lock at 10, then unmatched 14, then 6 twice
        pulse_after(10);
        pulse_after(10);
        check("lock10_valid", 32'(rate_valid), 1);
        pulse_after(14);
        check("p14_err", 32'(rate_err), 1);
        check("p14_valid", 32'(rate_valid), 0);
        check("p14_sel", 32'(rate_sel), 2);
        pulse_after(6);
        check("p6a_err", 32'(rate_err), 0);
        check("p6a_sel", 32'(rate_sel), 1);
        check("p6a_valid", 32'(rate_valid), 0);
        pulse_after(6);
        check("p6b_valid", 32'(rate_valid), 1);

        // Lock at 20, then silence until timeout
        pulse_after(20);
        pulse_after(20);
        check("lock20_valid", 32'(rate_valid), 1);
        repeat (29) tick(1'b0, 1'b0);
        check("pre_timeout", 32'(timeout), 0);
        tick(1'b0, 1'b0);
        check("timeout_set", 32'(timeout), 1);
        check("timeout_valid", 32'(rate_valid), 0);
        check("timeout_sel_hold", 32'(rate_sel), 3);
        check("timeout_period_hold", 32'(period_out), 20);
        repeat (5) tick(1'b0, 1'b0);
        check("timeout_sticky", 32'(timeout), 1);
        tick(1'b1, 1'b0);
        check("rearm_timeout_clr", 32'(timeout), 0);
        check("rearm_no_meas", 32'(new_meas), 0);
        pulse_after(10);
        check("rearm_meas", 32'(new_meas), 1);

        // Reset 4 clocks into a period-10 measurement, then re-lock
        repeat (4) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("midrst_sel", 32'(rate_sel), 0);
        check("midrst_period", 32'(period_out), 0);
        check("midrst_valid", 32'(rate_valid), 0);
        tick(1'b1, 1'b0);
        check("relock_arm", 32'(new_meas), 0);
        pulse_after(10);
        check("relock_p2_valid", 32'(rate_valid), 0);
        pulse_after(10);
        check("relock_p3_valid", 32'(rate_valid), 1);

        // Random gaps with occasional reset
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                tick(1'b0, 1'b1);
            end else begin
                case ($urandom_range(0, 5))
                    0:       gap = $urandom_range(1, 2);
                    1:       gap = $urandom_range(5, 7);
                    2:       gap = $urandom_range(9, 11);
                    3:       gap = $urandom_range(19, 21);
                    4:       gap = $urandom_range(12, 16);
                    default: gap = $urandom_range(25, 40);
                endcase
                pulse_after(gap);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
